// File: rtl/ros_meas_ctrl.sv
// ros_meas_ctrl: ring-oscillator measurement sequencer.
// Enables one RO at a time, lets it settle, counts rising edges of its prescaled
// output over a gate window, and hands each count off through a valid/ack register.
// Optional feature macro: ROS_MEAS_CONT_EN adds the `cont` input, which makes the
// sweep wrap around to the lowest masked RO instead of returning to idle.
module ros_meas_ctrl #(
    parameter int N_ROS      = 2,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 16,
    localparam int SEL_W     = (N_ROS > 1) ? $clog2(N_ROS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_ROS-1:0] ena_mask,
    input  logic [WIN_W-1:0] window,
    input  logic [N_ROS-1:0] ros_div,
`ifdef ROS_MEAS_CONT_EN
    input  logic             cont,
`endif
    output logic [N_ROS-1:0] ros_ena,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [CNT_W-1:0] res_count,
    output logic [SEL_W-1:0] res_sel,
    output logic             res_ovf
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_HANDOFF} state_t;

    state_t           state, state_nxt;
    logic [N_ROS-1:0] mask_q;
    logic [WIN_W-1:0] win_last;      // window-1, with 0 already mapped to a 1-cycle window
    logic [SEL_W-1:0] sel;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [N_ROS-1:0] sync1, sync2;
    logic             edge_q;

    // Lowest set bit of m at or above index lo; MSB of the result flags "found".
    function automatic logic [SEL_W:0] find_set(input logic [N_ROS-1:0] m, input int lo);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_ROS - 1; i >= 0; i--)
            if (i >= lo && m[i]) r = {1'b1, SEL_W'(i)};
        return r;
    endfunction

    logic [SEL_W:0] start_pick, next_pick, wrap_pick;
    logic           cont_w, load, adv_go, settle_done, meas_done, edge_hit;
    logic [SEL_W-1:0] adv_sel;

`ifdef ROS_MEAS_CONT_EN
    assign cont_w = cont;
`else
    assign cont_w = 1'b0;
`endif

    assign start_pick  = find_set(ena_mask, 0);
    assign next_pick   = find_set(mask_q, int'(sel) + 1);
    assign wrap_pick   = find_set(mask_q, 0);
    assign load        = (state == S_HANDOFF) && (!res_valid || res_ack);
    assign adv_go      = load && (next_pick[SEL_W] || (cont_w && wrap_pick[SEL_W]));
    assign adv_sel     = next_pick[SEL_W] ? next_pick[SEL_W-1:0] : wrap_pick[SEL_W-1:0];
    assign settle_done = (tmr == TMR_W'(SETTLE_CYC - 1));
    assign meas_done   = (tmr == TMR_W'(win_last));
    assign edge_hit    = sync2[sel] & ~edge_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; HANDOFF holds until the result register can take the count.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && start_pick[SEL_W]) state_nxt = S_SETTLE;
            S_SETTLE:  if (settle_done) state_nxt = S_MEASURE;
            S_MEASURE: if (meas_done) state_nxt = S_HANDOFF;
            S_HANDOFF: if (load) state_nxt = adv_go ? S_SETTLE : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs: the selected RO runs through settle and measure only.
    always_comb begin
        ros_ena = '0;
        busy    = (state != S_IDLE);
        if (state == S_SETTLE || state == S_MEASURE)
            ros_ena = N_ROS'(1) << sel;
    end

    // Per-lane 2-FF synchronizers plus one edge-detect FF on the selected lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= ros_div;
            sync2  <= sync1;
            edge_q <= sync2[sel];
        end
    end

    // Sequencing datapath: latched config, phase timer and saturating edge counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            win_last <= '0;
            sel      <= '0;
            tmr      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start && start_pick[SEL_W]) begin
                    mask_q   <= ena_mask;
                    win_last <= (window == '0) ? '0 : window - WIN_W'(1);
                    sel      <= start_pick[SEL_W-1:0];
                    tmr      <= '0;
                    cnt      <= '0;
                    ovf      <= 1'b0;
                end
                S_SETTLE: tmr <= settle_done ? '0 : tmr + TMR_W'(1);
                S_MEASURE: begin
                    tmr <= tmr + TMR_W'(1);
                    if (edge_hit) begin
                        if (cnt == '1) ovf <= 1'b1;
                        else           cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HANDOFF: if (adv_go) begin
                    sel <= adv_sel;
                    tmr <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Result register: a load wins over a coincident ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_count <= '0;
            res_sel   <= '0;
            res_ovf   <= 1'b0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_count <= cnt;
            res_sel   <= sel;
            res_ovf   <= ovf;
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ros_meas_ctrl.sv
// Directed bench for ros_meas_ctrl: reset, single RO, sweep, back-pressure,
// saturation (narrow-counter instance) and edge cases.
module tb_ros_meas_ctrl;

    logic        clk, reset;
    logic        start, res_ack;
    logic [1:0]  ena_mask;
    logic [15:0] window;
    logic [1:0]  ros_div, ros_ena;
    logic        busy, res_valid, res_ovf;
    logic [15:0] res_count;
    logic        res_sel;

    logic        start2, res_ack2;
    logic [1:0]  ena_mask2;
    logic [15:0] window2;
    logic [1:0]  ros_div2, ros_ena2;
    logic        busy2, res_valid2, res_ovf2;
    logic [3:0]  res_count2;
    logic        res_sel2;

    logic        w8, w4;
`ifdef ROS_MEAS_CONT_EN
    logic        cont;
`endif

    int checks = 0;
    int failures = 0;
    int n, nres, n01, n10, overlap, nogap, to;
    logic [1:0] prev;
    logic        sel0, sel1, busy_at;
    logic [15:0] cnt0, cnt1;

    ros_meas_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ena_mask(ena_mask), .window(window),
        .ros_div(ros_div),
`ifdef ROS_MEAS_CONT_EN
        .cont(cont),
`endif
        .ros_ena(ros_ena), .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
        .res_count(res_count), .res_sel(res_sel), .res_ovf(res_ovf)
    );

    ros_meas_ctrl #(.CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ena_mask(ena_mask2), .window(window2),
        .ros_div(ros_div2),
`ifdef ROS_MEAS_CONT_EN
        .cont(1'b0),
`endif
        .ros_ena(ros_ena2), .busy(busy2), .res_valid(res_valid2), .res_ack(res_ack2),
        .res_count(res_count2), .res_sel(res_sel2), .res_ovf(res_ovf2)
    );

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    // Prescaled RO outputs: period 8 clk for dut, period 4 clk for dut2, off the clk grid.
    initial begin w8 = 1'b0; #3; forever #40 w8 = ~w8; end
    initial begin w4 = 1'b0; #7; forever #20 w4 = ~w4; end
    assign ros_div  = {2{w8}};
    assign ros_div2 = {2{w4}};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; res_ack = 1'b0; ena_mask = 2'b00; window = '0;
        start2 = 1'b0; res_ack2 = 1'b0; ena_mask2 = 2'b00; window2 = '0;
`ifdef ROS_MEAS_CONT_EN
        cont = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_ena", ros_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", res_count, 0);
        chk("rst_sel", res_sel, 0);
        chk("rst_ovf", res_ovf, 0);

        // start with empty mask is ignored
        ena_mask = 2'b00; window = 16'd10; start = 1'b1; tick(); start = 1'b0;
        chk("mask0_busy", busy, 0);
        tick();
        chk("mask0_ena", ros_ena, 0);

        // single RO, window 100, period 8 -> 12 or 13 edges, enable for 16+100 cycles
        ena_mask = 2'b01; window = 16'd100; start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (ros_ena == 2'b01 && n < 300) begin n++; tick(); end
        chk("t2_ena_cycles", n, 116);
        tick();
        chk("t2_valid", res_valid, 1);
        chk("t2_busy", busy, 0);
        chk("t2_sel", res_sel, 0);
        chk("t2_count_12_13", (res_count >= 12 && res_count <= 13), 1);
        chk("t2_ovf", res_ovf, 0);
        res_ack = 1'b1; tick(); res_ack = 1'b0;
        chk("t2_ack_clears", res_valid, 0);

        // two-RO sweep, ack tied high; config changes and a start mid-sweep are ignored
        ena_mask = 2'b11; window = 16'd64; res_ack = 1'b1; start = 1'b1; tick(); start = 1'b0;
        ena_mask = 2'b01; window = 16'd5;
        nres = 0; n01 = 0; n10 = 0; overlap = 0; nogap = 0; prev = 2'b00;
        sel0 = 1'b1; sel1 = 1'b0; cnt0 = '0; cnt1 = '0; busy_at = 1'b1;
        for (int i = 0; i < 170; i++) begin
            if (ros_ena == 2'b11) overlap++;
            if (ros_ena == 2'b01) n01++;
            if (ros_ena == 2'b10) n10++;
            if (prev == 2'b01 && ros_ena == 2'b10) nogap++;
            prev = ros_ena;
            if (res_valid) begin
                if (nres == 0) begin sel0 = res_sel; cnt0 = res_count; end
                else if (nres == 1) begin sel1 = res_sel; cnt1 = res_count; busy_at = busy; end
                nres++;
            end
            start = (i == 10);
            tick();
        end
        start = 1'b0; res_ack = 1'b0;
        chk("t3_nres", nres, 2);
        chk("t3_sel0", sel0, 0);
        chk("t3_sel1", sel1, 1);
        chk("t3_cnt0_7_9", (cnt0 >= 7 && cnt0 <= 9), 1);
        chk("t3_cnt1_7_9", (cnt1 >= 7 && cnt1 <= 9), 1);
        chk("t3_ena01_cycles", n01, 80);
        chk("t3_ena10_cycles", n10, 80);
        chk("t3_overlap", overlap, 0);
        chk("t3_nogap", nogap, 0);
        chk("t3_busy_at_last", busy_at, 0);

        // back-pressure: RO1 result stalls in HANDOFF until ack
        ena_mask = 2'b11; window = 16'd20; start = 1'b1; tick(); start = 1'b0;
        repeat (100) tick();
        chk("t4_stall_busy", busy, 1);
        chk("t4_stall_ena", ros_ena, 0);
        chk("t4_stall_valid", res_valid, 1);
        chk("t4_stall_sel", res_sel, 0);
        chk("t4_cnt0_2_3", (res_count >= 2 && res_count <= 3), 1);
        res_ack = 1'b1; tick(); res_ack = 1'b0;
        chk("t4_load_valid", res_valid, 1);
        chk("t4_load_sel", res_sel, 1);
        chk("t4_load_busy", busy, 0);
        chk("t4_cnt1_2_3", (res_count >= 2 && res_count <= 3), 1);

        // reset in the middle of MEASURE (result register still full)
        ena_mask = 2'b01; window = 16'd100; start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        chk("t1_pre_busy", busy, 1);
        reset = 1'b1; tick();
        chk("t1_ena", ros_ena, 0);
        chk("t1_busy", busy, 0);
        chk("t1_valid", res_valid, 0);
        chk("t1_count", res_count, 0);
        reset = 1'b0; tick();

        // window 0 behaves as a 1-cycle window
        ena_mask = 2'b01; window = 16'd0; start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (ros_ena == 2'b01 && n < 300) begin n++; tick(); end
        chk("t6_win0_cycles", n, 17);
        tick();
        chk("t6_win0_valid", res_valid, 1);
        chk("t6_win0_count_le1", (res_count <= 1), 1);
        res_ack = 1'b1; tick(); res_ack = 1'b0;

        // saturation on the 4-bit instance: 50 edges -> 15 with overflow
        ena_mask2 = 2'b01; window2 = 16'd200; start2 = 1'b1; tick(); start2 = 1'b0;
        to = 0;
        while (!res_valid2 && to < 400) begin to++; tick(); end
        chk("t5_timeout", (to < 400), 1);
        chk("t5_count", res_count2, 15);
        chk("t5_ovf", res_ovf2, 1);
        chk("t5_busy", busy2, 0);

`ifdef ROS_MEAS_CONT_EN
        // continuous sweep on RO1 only
        cont = 1'b1; res_ack = 1'b1; ena_mask = 2'b10; window = 16'd4;
        start = 1'b1; tick(); start = 1'b0;
        nres = 0; n = 0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid) begin nres++; if (res_sel != 1'b1) n++; end
            tick();
        end
        chk("cont_results_ge4", (nres >= 4), 1);
        chk("cont_sel_all1", n, 0);
        chk("cont_busy", busy, 1);
        cont = 1'b0;
        to = 0;
        while (busy && to < 100) begin to++; tick(); end
        chk("cont_stop", busy, 0);
        res_ack = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
